// File: rtl/alu_pkg.sv
// Shared ALU types: add/sub op encoding and the
// two's-complement signed overflow helper.
package alu_pkg;

  typedef logic op_t;

  localparam op_t OP_ADD = 1'b0;
  localparam op_t OP_SUB = 1'b1;

  function automatic logic ovf_flag(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/add_slice.sv
// W-bit combinational ripple-carry full-adder chain.
// Ports: a, b (W), ci -> s (W), co.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[W];

endmodule

// File: rtl/pipelined_add_sub.sv
// N-bit add/sub in STAGES registered carry segments, valid/ready both sides.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, op, out_valid/out_ready,
// sum, cout, ovf. Macro PIPELINED_ADD_SUB_SATURATE_EN clamps sum on ovf.
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  op_t          op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int W = N / STAGES;
  localparam int L = STAGES - 1;

  if (STAGES < 1 || STAGES > N) begin : g_bad_stages
    $error("STAGES must be in 1..N");
  end
  if (N % STAGES != 0) begin : g_bad_split
    $error("N must be a multiple of STAGES");
  end

  logic              advance;
  logic [N-1:0]      b_eff;
  logic              c_eff;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [N-1:0]      a_q [STAGES];
  logic [N-1:0]      b_q [STAGES];
  logic [N-1:0]      s_q [STAGES];
  logic              ovf_q;

  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [N-1:0]      src_a [STAGES];
  logic [N-1:0]      src_b [STAGES];
  logic [N-1:0]      src_s [STAGES];

  logic [W-1:0]      sl_s [STAGES];
  logic [STAGES-1:0] sl_co;

  logic [N-1:0]      s_d [STAGES];
  logic              ovf_d;

  assign advance   = !v_q[L] | out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[L];
  assign sum       = s_q[L];
  assign cout      = c_q[L];
  assign ovf       = ovf_q;

  // SUB is a + ~b + 1, so cin is replaced by the forced 1.
  always_comb begin
    b_eff = b;
    c_eff = cin;
    unique case (op)
      OP_ADD: begin
        b_eff = b;
        c_eff = cin;
      end
      OP_SUB: begin
        b_eff = ~b;
        c_eff = 1'b1;
      end
      default: begin
        b_eff = b;
        c_eff = cin;
      end
    endcase
  end

  // Stage 0 reads the port, later stages read the previous rank.
  always_comb begin
    src_v    = '0;
    src_c    = '0;
    src_v[0] = in_valid;
    src_c[0] = c_eff;
    src_a[0] = a;
    src_b[0] = b_eff;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_c[k] = c_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_seg
    add_slice #(
      .W (W)
    ) u_slice (
      .a  (src_a[g][g*W +: W]),
      .b  (src_b[g][g*W +: W]),
      .ci (src_c[g]),
      .s  (sl_s[g]),
      .co (sl_co[g])
    );
  end

  // Merge each new slice into the skewed partial sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_d[k]            = src_s[k];
      s_d[k][k*W +: W]  = sl_s[k];
    end
    ovf_d = ovf_flag(src_a[L][N-1],
                     src_b[L][N-1],
                     s_d[L][N-1]);
`ifdef PIPELINED_ADD_SUB_SATURATE_EN
    // Sign of a tells which rail the true result overran.
    if (ovf_d) begin
      if (src_a[L][N-1]) begin
        s_d[L] = {1'b1, {(N-1){1'b0}}};
      end else begin
        s_d[L] = {1'b0, {(N-1){1'b1}}};
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q   <= src_v;
      c_q   <= sl_co;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= src_a[k];
        b_q[k] <= src_b[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  // Skew ranks carry whole words; only some bits are consumed downstream.
  logic unused_q;
  always_comb begin
    unused_q = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      unused_q = unused_q ^ (^a_q[k]) ^ (^b_q[k]) ^ (^s_q[k]);
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub: (8,2) directed plus
// (8,1), (16,4), (32,8) sharing stimulus under a random run.
module tb_pipelined_add_sub;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        fr;
    logic [31:0] t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;

  logic        irdy [4];
  logic        ovld [4];
  logic        oc   [4];
  logic        oo   [4];
  logic [31:0] os   [4];

  logic [7:0]  s0;
  logic [7:0]  s1;
  logic [15:0] s2;
  logic [31:0] s3;

  assign os[0] = {24'b0, s0};
  assign os[1] = {24'b0, s1};
  assign os[2] = {16'b0, s2};
  assign os[3] = s3;

  always #5 clk = ~clk;

  pipelined_add_sub #(.N(8), .STAGES(2)) u_d0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(irdy[0]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .op(op),
    .out_valid(ovld[0]), .out_ready(out_ready),
    .sum(s0), .cout(oc[0]), .ovf(oo[0])
  );

  pipelined_add_sub #(.N(8), .STAGES(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(irdy[1]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .op(op),
    .out_valid(ovld[1]), .out_ready(out_ready),
    .sum(s1), .cout(oc[1]), .ovf(oo[1])
  );

  pipelined_add_sub #(.N(16), .STAGES(4)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(irdy[2]),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .op(op),
    .out_valid(ovld[2]), .out_ready(out_ready),
    .sum(s2), .cout(oc[2]), .ovf(oo[2])
  );

  pipelined_add_sub #(.N(32), .STAGES(8)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(irdy[3]),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(ovld[3]), .out_ready(out_ready),
    .sum(s3), .cout(oc[3]), .ovf(oo[3])
  );

  int          n_asrt = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          stg [4] = '{2, 1, 4, 8};
  int          nw  [4] = '{8, 8, 16, 32};
  int          pops [4];
  exp_t        sbq [4][$];
  logic        free_run;
  logic        acc0;
  logic        hold_v [4];
  logic [31:0] hold_s [4];
  logic        hold_c [4];
  logic        hold_o [4];

  task automatic chk(input string tag, input int idx,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: got=%0h want=%0h", tag, idx, got, exp);
    end
  endtask

  function automatic exp_t model(input int n,
                                 input logic [31:0] x,
                                 input logic [31:0] y,
                                 input logic ci,
                                 input logic o);
    logic [63:0] m, xa, yb, full;
    exp_t        e;
    m    = (64'd1 << n) - 64'd1;
    xa   = {32'b0, x} & m;
    yb   = (o ? ~{32'b0, y} : {32'b0, y}) & m;
    full = xa + yb + (o ? 64'd1 : {63'b0, ci});
    e.s  = full[31:0] & m[31:0];
    e.c  = full[n];
    e.o  = (xa[n-1] == yb[n-1]) && (full[n-1] != xa[n-1]);
`ifdef PIPELINED_ADD_SUB_SATURATE_EN
    if (e.o) e.s = xa[n-1] ? (m[31:0] ^ (m[31:0] >> 1)) : (m[31:0] >> 1);
`endif
    e.fr = 1'b0;
    e.t  = '0;
    return e;
  endfunction

  // One clock: check/pop outputs and push accepted beats at the negedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc0 = rst_n && in_valid && irdy[0];
    for (int i = 0; i < 4; i++) begin
      if (rst_n && hold_v[i]) begin
        chk("hold_valid", i, 32'(ovld[i]), 32'd1);
        chk("hold_sum", i, os[i], hold_s[i]);
        chk("hold_cout", i, 32'(oc[i]), 32'(hold_c[i]));
        chk("hold_ovf", i, 32'(oo[i]), 32'(hold_o[i]));
      end
      if (rst_n && ovld[i] && !out_ready) begin
        chk("stall_rdy", i, 32'(irdy[i]), 32'd0);
      end
      hold_v[i] = rst_n && ovld[i] && !out_ready;
      hold_s[i] = os[i];
      hold_c[i] = oc[i];
      hold_o[i] = oo[i];
      if (rst_n && ovld[i] && out_ready) begin
        pops[i]++;
        chk("beat_expected", i, 32'(sbq[i].size() != 0), 32'd1);
        if (sbq[i].size() != 0) begin
          e = sbq[i].pop_front();
          chk("sum", i, os[i], e.s);
          chk("cout", i, 32'(oc[i]), 32'(e.c));
          chk("ovf", i, 32'(oo[i]), 32'(e.o));
          if (e.fr && free_run) begin
            chk("latency", i, 32'(cyc) - e.t, 32'(stg[i]));
          end
        end
      end
      if (rst_n && in_valid && irdy[i]) begin
        e    = model(nw[i], a, b, cin, op);
        e.t  = 32'(cyc);
        e.fr = free_run;
        sbq[i].push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", i, 32'(ovld[i]), 32'd0);
      chk("rst_sum", i, os[i], 32'd0);
      chk("rst_cout", i, 32'(oc[i]), 32'd0);
      chk("rst_ovf", i, 32'(oo[i]), 32'd0);
      sbq[i].delete();
      pops[i]   = 0;
      hold_v[i] = 1'b0;
    end
  endtask

  task automatic send_chk(input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic o,
                          input logic [31:0] es, input logic ec,
                          input logic eo);
    a        = x;
    b        = y;
    cin      = ci;
    op       = o;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !ovld[0]; k++) step();
    chk("dir_valid", 0, 32'(ovld[0]), 32'd1);
    chk("dir_sum", 0, os[0], es);
    chk("dir_cout", 0, 32'(oc[0]), 32'(ec));
    chk("dir_ovf", 0, 32'(oo[0]), 32'(eo));
  endtask

  task automatic drain_and_check();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) step();
    for (int i = 0; i < 4; i++) begin
      chk("sb_empty", i, 32'(sbq[i].size()), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ba [6];
    logic [31:0] bb [6];
    int          j;
    int          c;

    free_run  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 32'h12;
    b         = 32'h34;
    cin       = 1'b1;
    op        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hold_v[i] = 1'b0;
      pops[i]   = 0;
    end
    #1;

    // Reset held with a beat offered.
    apply_reset();
    step();
    step();
    chk("rst_hold_valid", 0, 32'(ovld[0]), 32'd0);
    chk("rst_hold_sum", 0, os[0], 32'd0);
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #1;
    chk("rdy_after_rst", 0, 32'(irdy[0]), 32'd1);
    out_ready = 1'b1;
    free_run  = 1'b1;

    // Latency: exactly two cycles for the (8,2) unit.
    a        = 32'h12;
    b        = 32'h34;
    cin      = 1'b1;
    op       = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_early", 0, 32'(ovld[0]), 32'd0);
    step();
    chk("lat_two", 0, 32'(ovld[0]), 32'd1);
    chk("lat_sum", 0, os[0], 32'h47);
    chk("lat_cout", 0, 32'(oc[0]), 32'd0);
    chk("lat_ovf", 0, 32'(oo[0]), 32'd0);

    send_chk(32'h0F, 32'h01, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0);
    send_chk(32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0);
    send_chk(32'h00, 32'h01, 1'b0, 1'b1, 32'hFF, 1'b0, 1'b0);
`ifdef PIPELINED_ADD_SUB_SATURATE_EN
    send_chk(32'h80, 32'h01, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1);
    send_chk(32'h7F, 32'h01, 1'b0, 1'b0, 32'h7F, 1'b0, 1'b1);
`else
    send_chk(32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1);
    send_chk(32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1);
`endif
    drain_and_check();

    // Back-pressure: six beats, out_ready low for three cycles.
    free_run = 1'b0;
    for (int i = 0; i < 4; i++) pops[i] = 0;
    for (int i = 0; i < 6; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    j = 0;
    c = 0;
    while (j < 6 && c < 40) begin
      a         = ba[j];
      b         = bb[j];
      cin       = ba[j][3];
      op        = bb[j][5];
      in_valid  = 1'b1;
      out_ready = !(c >= 3 && c < 6);
      step();
      if (acc0) j++;
      c++;
    end
    chk("bp_sent", 0, 32'(j), 32'd6);
    drain_and_check();
    chk("bp_count", 0, 32'(pops[0]), 32'd6);

    // Reset with two beats in flight: neither may emerge.
    a        = 32'h21;
    b        = 32'h43;
    op       = 1'b0;
    in_valid = 1'b1;
    step();
    a = 32'h65;
    step();
    in_valid = 1'b0;
    chk("rst_pre_valid", 0, 32'(ovld[0]), 32'd1);
    apply_reset();
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) step();
    chk("rst_no_ghost", 0, 32'(pops[0]), 32'd0);

    // Random run, all four configurations, no back-pressure.
    free_run = 1'b1;
    for (int k = 0; k < 300; k++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      a        = $urandom;
      b        = $urandom;
      cin      = 1'($urandom_range(0, 1));
      op       = 1'($urandom_range(0, 1));
      step();
    end
    free_run = 1'b0;

    // Random run with random back-pressure.
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      op        = 1'($urandom_range(0, 1));
      step();
    end
    drain_and_check();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
